// File: rtl/serial_rx.sv
// serial_rx: asynchronous serial receiver (idle high, start low, LSB first, stop high).
// Optional even-parity bit between data and stop when SERIAL_RX_PARITY_EN is defined.
module serial_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  // state  | meaning
  // IDLE   | waiting for a falling edge on the synchronized line
  // START  | half-bit wait, then confirm the start bit is still low
  // DATA   | full-bit waits, sampling DATA_BITS data bits LSB first
  // PARITY | full-bit wait, then compare against even parity (SERIAL_RX_PARITY_EN only)
  // STOP   | full-bit wait, then check stop bit and emit the result

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t               state, state_n;
  logic                 rx_meta, rx_s, rx_d;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, ferr_n, perr_n;
  logic                 tc;

`ifdef SERIAL_RX_PARITY_EN
  logic perr_flag, perr_flag_n;
`endif

  // Synchronizer and edge-detect flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      data_out   <= data_n;
      data_valid <= valid_n;
      frame_err  <= ferr_n;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_flag  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      perr_flag  <= perr_flag_n;
      parity_err <= perr_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign tc   = (cnt == '0);

  // Bit timer is a down-counter loaded with the wait length; sampling happens at zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_out;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    perr_flag_n = perr_flag;
`endif

    case (state)
      IDLE: begin
        if (rx_d && !rx_s) begin
          state_n = START;
          cnt_n   = HALF_TC;
        end
      end

      START: begin
        if (tc) begin
          if (!rx_s) begin
            state_n = DATA;
            cnt_n   = FULL_TC;
            idx_n   = '0;
`ifdef SERIAL_RX_PARITY_EN
            perr_flag_n = 1'b0;
`endif
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      DATA: begin
        if (tc) begin
          shreg_n[idx] = rx_s;
          cnt_n        = FULL_TC;
          if (idx == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (tc) begin
          perr_flag_n = (rx_s != ^shreg);
          cnt_n       = FULL_TC;
          state_n     = STOP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif

      STOP: begin
        if (tc) begin
          // Leaving at mid-stop lets a back-to-back start edge be caught without a gap.
          state_n = IDLE;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            perr_n  = perr_flag;
`endif
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx; frames are built bit by bit and the
// expected result and arrival cycle are queued when each frame starts.
module tb_serial_rx;
  localparam int N  = 16;
  localparam int DB = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = 2 + N / 2 + (DB + 1 + P) * N + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid, frame_err, parity_err, busy;

  serial_rx #(.CLKS_PER_BIT(N), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    bit            good;
    bit            perr;
    logic [DB-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad   = 0;
  logic [DB-1:0] last_good = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (data_valid || frame_err || parity_err)) begin
      chk("valid_and_ferr_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, data_valid, frame_err, parity_err}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.due);
        chk("data_valid", {31'd0, data_valid}, {31'd0, e.good});
        chk("frame_err", {31'd0, frame_err}, {31'd0, !e.good});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        chk("data_out", 32'(data_out), 32'(e.data));
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (N) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Must be called at a negedge; the start bit falls there.
  task automatic send(input logic [DB-1:0] d, input bit stop_ok, input bit par_ok);
    exp_t e;
    e.good = stop_ok;
    e.perr = stop_ok && (P != 0) && !par_ok;
    e.data = stop_ok ? d : last_good;
    e.due  = cyc + LAT;
    if (stop_ok) last_good = d;
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (P != 0) drive_bit(par_ok ? ^d : ~^d);
    drive_bit(stop_ok);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", q.size(), 32'd0);
  endtask

  initial begin
    int nz;
    bit seen;
    logic [DB-1:0] a;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_pulses", {29'd0, data_valid, frame_err, parity_err}, 32'd0);

    nz = 0;
    repeat (1000) begin
      @(negedge clk);
      if (data_valid || frame_err || parity_err || busy || data_out != '0) nz++;
    end
    chk("idle_quiet_cycles", nz, 32'd0);

    send(8'hA5, 1, 1);
    idle(5);

    send(8'h3C, 1, 1);
    send(8'hC3, 1, 1);
    idle(5);
    drain(LAT + 20);

    // Short low glitch: START must reject it.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    seen = 0;
    repeat (N) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("glitch_busy_seen", {31'd0, seen}, 32'd1);
    chk("glitch_back_idle", {31'd0, busy}, 32'd0);
    idle(4);
    send(8'h55, 1, 1);
    idle(5);

    // Bad stop, then a held break: exactly one frame_err.
    send(8'hFF, 0, 1);
    rx = 1'b0;
    repeat (500) @(negedge clk);
    chk("break_busy_low", {31'd0, busy}, 32'd0);
    idle(5);
    drain(LAT + 20);

    // Reset during data bit 4 of 0x12.
    a = 8'h12;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(a[i]);
    rx = a[4];
    repeat (N / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;
    last_good = '0;
    idle(5);
    send(8'h34, 1, 1);
    idle(5);

    if (P != 0) begin
      send(8'h07, 1, 0);
      idle(5);
    end

    // Randomized frames, gaps and bad stop/parity bits.
    for (int k = 0; k < 30; k++) begin
      logic [DB-1:0] d;
      bit so, po;
      d  = DB'($urandom);
      so = ($urandom_range(0, 5) != 0);
      po = ($urandom_range(0, 4) != 0);
      send(d, so, po);
      idle(so ? int'($urandom_range(0, 4)) : int'($urandom_range(2, 6)));
    end

    drain(LAT + 50);
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_rx.md
# serial_rx

- Asynchronous serial receiver: the receiving end of the send/receive link.
- Samples the single-wire line `rx` (idle high, start bit low, data LSB first, stop bit high), after it has passed through the link's fixed propagation delay.
- Recovers each frame into a parallel byte with a one-cycle valid strobe.
- Sits at the far end of the channel opposite the serial transmitter and feeds the downstream consumer logic.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit (N). Even, ≥4.
- `DATA_BITS`, 8: data bits per frame (1–8).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `data_out`  out  DATA_BITS  last good received word, LSB = first bit on wire.
- `data_valid`  out  1  one-cycle pulse: `data_out` just updated.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Constant 0 without `SERIAL_RX_PARITY_EN`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1), giving `rx_s`. A further flop `rx_d` holds the previous `rx_s` for edge detection.
- The bit counter is wide enough for N−1. The data bit index is wide enough for DATA_BITS−1.
- States:
  - IDLE: wait for `rx_d`=1 and `rx_s`=0 (falling edge). On the edge, clear the counter and go to START.
  - START: count to N/2−1, then sample `rx_s`.
    - If 0: go to DATA, bit index 0, counter cleared.
    - If 1 (glitch): return to IDLE with no pulse output.
  - DATA: count to N−1, then sample `rx_s` into shift register position `index`.
    - After bit DATA_BITS−1, go to PARITY if the macro is defined, else to STOP.
  - PARITY (macro only): count to N−1, then sample. Mismatch vs. even parity of the data sets the error flag. Go to STOP.
  - STOP: count to N−1, then sample.
    - If 1: load `data_out` from the shift register and pulse `data_valid`. `parity_err` pulses in the same cycle if the flag is set.
    - If 0: pulse `frame_err`; `data_out` is unchanged and no `parity_err`.
    - Either way, return to IDLE in the same cycle.
- Return to IDLE at mid-stop lets a back-to-back start bit be caught with no gap.
- Line held low (break): STOP samples 0 and `frame_err` pulses once. IDLE needs a real falling edge, so there is no re-trigger until `rx` returns high and falls again.
- `data_valid` and `frame_err` are never high together.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0; FSM in IDLE; sync flops and `rx_d` = 1.
- Reset mid-frame aborts immediately with no pulse. The first frame after reset needs a fresh falling edge.
- Let E be the cycle on which the edge is seen in IDLE. E is 2 cycles after `rx` falls, because of the synchronizer. `busy` rises at E+1.
- Start sampled at E+N/2.
- Data bit i sampled at E+N/2+(i+1)·N.
- Parity sampled at E+N/2+(DATA_BITS+1)·N.
- Stop sampled at E+N/2+(DATA_BITS+1+P)·N, where P=1 with the macro, else 0.
- `data_valid` / `frame_err` / `parity_err` are registered: high for exactly one cycle, the cycle after the stop sample. `busy` falls in that same cycle.
- Total `rx`-fall to `data_valid` latency = 2 + N/2 + (DATA_BITS+1+P)·N + 1 cycles.
  - Defaults, no parity: 2+8+144+1 = 155.

## Configuration
- Macro: `SERIAL_RX_PARITY_EN`.
- Defined: the frame carries one even-parity bit between data and stop. The PARITY state exists and `parity_err` is live.
- Undefined: no PARITY state, frame = start + DATA_BITS + stop, and `parity_err` is tied 0.

## Test plan
1. After reset with `rx`=1 held: all outputs 0 for 1000 cycles; `busy` stays 0.
2. Send 0xA5 at N=16, defaults: `data_out`=0xA5. `data_valid` is a single pulse exactly 155 cycles after the start edge; `frame_err` stays 0.
3. Send 0x3C then 0xC3 back-to-back with no idle gap: two `data_valid` pulses 160 cycles apart with `data_out` 0x3C then 0xC3.
4. Low glitch of 3 cycles on idle `rx`: `busy` high briefly, then IDLE with no pulses. A following 0x55 frame is received correctly.
5. Frame 0xFF with stop bit forced 0: `frame_err` pulses once, `data_valid` stays 0, and `data_out` holds its previous value. Then hold `rx` low for 500 cycles: no further pulses.
6. Assert `rst` at data bit 4 of 0x12, release, then send 0x34: no pulse for the aborted frame and `data_out`=0x34 on the next `data_valid`.
   - With `SERIAL_RX_PARITY_EN` defined, also send 0x07 with parity bit 0 (bad): `parity_err` and `data_valid` pulse in the same cycle.
